// File: rtl/io_stress_test_initiator.sv
// Host-side initiator for the GLIP I/O stress test: sends command, seed and count
// to the responder, then runs a write or read LFSR stream and reports the verdict.

module stress_test_lfsr #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             load,
  input  logic [WIDTH-1:0] seed,
  input  logic             advance,
  output logic [WIDTH-1:0] value
);

  // Galois right-shift taps x^W + x^(W-2) + x^(W-3) + x^(W-5); maximal length at W = 16.
  localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] TAPS = (ONE << (WIDTH-1)) | (ONE << (WIDTH-3)) |
                                      (ONE << (WIDTH-4)) | (ONE << (WIDTH-6));

  logic [WIDTH-1:0] value_q, value_d;

  always_comb begin
    // NOTE: assigning a default first means every path drives value_d, so no latch is inferred.
    value_d = value_q;
    if (load) begin
      value_d = seed;
    end else if (advance) begin
      value_d = (value_q >> 1) ^ ({WIDTH{value_q[0]}} & TAPS);
    end
  end

  // NOTE: the LFSR state is deliberately left out of reset; it is always seeded before use.
  always_ff @(posedge clk) begin
    value_q <= value_d;
  end

  assign value = value_q;

endmodule

module io_stress_test_initiator #(
  parameter int WIDTH             = 16,
  parameter int WORD_COUNT_LSHIFT = 20,
  parameter int TIMEOUT_CYCLES    = 65535
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             test_dir,
  input  logic             rnd_wait,
  input  logic [WIDTH-1:0] seed,
  input  logic [15:0]      word_count,
  input  logic             stall,
  output logic             fifo_out_valid,
  input  logic             fifo_out_ready,
  output logic [WIDTH-1:0] fifo_out_data,
  input  logic             fifo_in_valid,
  output logic             fifo_in_ready,
  input  logic [WIDTH-1:0] fifo_in_data,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             fail,
  output logic             timeout,
  output logic [WIDTH-1:0] err_received,
  output logic [WIDTH-1:0] err_expected
);

  localparam logic [15:0] KW_WR      = 16'h420A;
  localparam logic [15:0] KW_WR_RND  = 16'h421A;
  localparam logic [15:0] KW_RD      = 16'h420B;
  localparam logic [15:0] KW_RD_RND  = 16'h421B;
  localparam logic [15:0] KW_SUCCESS = 16'hCAFE;
  localparam logic [15:0] KW_ERROR   = 16'hDEAD;

  localparam int              TO_W           = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TO_W-1:0] TO_LIMIT       = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [35:0]     BYTES_PER_WORD = 36'(WIDTH / 8);

  typedef enum logic [3:0] {
    S_IDLE,
    S_SEND_CMD,
    S_SEND_SEED,
    S_SEND_COUNT,
    S_WR_STREAM,
    S_WR_RESULT,
    S_WR_ERR_RX,
    S_WR_ERR_EXP,
    S_RD_STREAM,
    S_RD_SEND_ERROR,
    S_RD_SEND_SUCCESS,
    S_DONE
  } state_t;

  function automatic logic [WIDTH-1:0] kw(input logic [15:0] k);
    kw = '0;
    kw[15:0] = k;
  endfunction

  state_t           state_q, state_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [35:0]      bcnt_q, bcnt_d;
  logic [TO_W-1:0]  idle_q, idle_d;
  logic             dir_q, dir_d;
  logic [WIDTH-1:0] seed_q, seed_d;
  logic [15:0]      wcnt_q, wcnt_d;
  logic             pass_q, pass_d;
  logic             fail_q, fail_d;
  logic             timeout_q, timeout_d;
  logic [WIDTH-1:0] err_rx_q, err_rx_d;
  logic [WIDTH-1:0] err_exp_q, err_exp_d;

  logic             lfsr_load, lfsr_adv;
  logic [WIDTH-1:0] lfsr_value;
  logic             stream_hold, out_hs, in_hs, in_ready, active;
  logic [35:0]      bcnt_next;
  logic [15:0]      cmd_word;

  stress_test_lfsr #(.WIDTH(WIDTH)) u_lfsr (
    .clk     (clk),
    .load    (lfsr_load),
    .seed    (seed_q),
    .advance (lfsr_adv),
    .value   (lfsr_value)
  );

  // During the write stream the LFSR register itself is the data word, so it holds until accepted.
  assign stream_hold    = (state_q == S_WR_STREAM) && stall;
  assign fifo_out_valid = out_valid_q && !stream_hold;
  assign fifo_out_data  = (state_q == S_WR_STREAM) ? lfsr_value : out_data_q;
  assign out_hs         = fifo_out_valid && fifo_out_ready;
  assign in_hs          = fifo_in_valid && in_ready;
  assign fifo_in_ready  = in_ready;

  assign active    = (state_q != S_IDLE) && (state_q != S_DONE);
  assign bcnt_next = (bcnt_q > BYTES_PER_WORD) ? bcnt_q - BYTES_PER_WORD : '0;

  always_comb begin
    in_ready = 1'b0;
    case (state_q)
      S_WR_STREAM:                            in_ready = fifo_in_valid && (fifo_in_data == kw(KW_ERROR));
      S_WR_RESULT, S_WR_ERR_RX, S_WR_ERR_EXP: in_ready = 1'b1;
      S_RD_STREAM:                            in_ready = !stall;
      default:                                in_ready = 1'b0;
    endcase
  end

  always_comb begin
    case ({test_dir, rnd_wait})
      2'b00:   cmd_word = KW_WR;
      2'b01:   cmd_word = KW_WR_RND;
      2'b10:   cmd_word = KW_RD;
      default: cmd_word = KW_RD_RND;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    bcnt_d      = bcnt_q;
    idle_d      = idle_q;
    dir_d       = dir_q;
    seed_d      = seed_q;
    wcnt_d      = wcnt_q;
    pass_d      = pass_q;
    fail_d      = fail_q;
    timeout_d   = timeout_q;
    err_rx_d    = err_rx_q;
    err_exp_d   = err_exp_q;
    lfsr_load   = 1'b0;
    lfsr_adv    = 1'b0;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d     = S_SEND_CMD;
          dir_d       = test_dir;
          seed_d      = seed;
          wcnt_d      = word_count;
          bcnt_d      = 36'(word_count) << WORD_COUNT_LSHIFT;
          pass_d      = 1'b0;
          fail_d      = 1'b0;
          timeout_d   = 1'b0;
          err_rx_d    = '0;
          err_exp_d   = '0;
          out_valid_d = 1'b1;
          out_data_d  = kw(cmd_word);
        end
      end
      S_SEND_CMD: begin
        if (out_hs) begin
          state_d    = S_SEND_SEED;
          out_data_d = seed_q;
        end
      end
      S_SEND_SEED: begin
        if (out_hs) begin
          state_d    = S_SEND_COUNT;
          out_data_d = kw(wcnt_q);
          lfsr_load  = 1'b1;
        end
      end
      S_SEND_COUNT: begin
        if (out_hs) begin
          if (!dir_q) begin
            state_d     = (bcnt_q == '0) ? S_WR_RESULT : S_WR_STREAM;
            out_valid_d = (bcnt_q != '0);
          end else if (bcnt_q == '0) begin
            state_d    = S_RD_SEND_SUCCESS;
            out_data_d = kw(KW_SUCCESS);
          end else begin
            state_d     = S_RD_STREAM;
            out_valid_d = 1'b0;
          end
        end
      end
      S_WR_STREAM: begin
        if (in_hs) begin
          state_d     = S_WR_ERR_RX;
          out_valid_d = 1'b0;
        end else if (out_hs) begin
          lfsr_adv = 1'b1;
          bcnt_d   = bcnt_next;
          if (bcnt_next == '0) begin
            state_d     = S_WR_RESULT;
            out_valid_d = 1'b0;
          end
        end
      end
      S_WR_RESULT: begin
        if (in_hs) begin
          if (fifo_in_data == kw(KW_SUCCESS)) begin
            state_d = S_DONE;
            pass_d  = 1'b1;
          end else if (fifo_in_data == kw(KW_ERROR)) begin
            state_d = S_WR_ERR_RX;
          end else begin
            state_d  = S_DONE;
            fail_d   = 1'b1;
            err_rx_d = fifo_in_data;
          end
        end
      end
      S_WR_ERR_RX: begin
        if (in_hs) begin
          state_d  = S_WR_ERR_EXP;
          err_rx_d = fifo_in_data;
        end
      end
      S_WR_ERR_EXP: begin
        if (in_hs) begin
          state_d   = S_DONE;
          fail_d    = 1'b1;
          err_exp_d = fifo_in_data;
        end
      end
      S_RD_STREAM: begin
        // A mismatch is checked before the counter so it wins on the final word.
        if (in_hs) begin
          if (fifo_in_data != lfsr_value) begin
            state_d     = S_RD_SEND_ERROR;
            err_rx_d    = fifo_in_data;
            err_exp_d   = lfsr_value;
            out_valid_d = 1'b1;
            out_data_d  = kw(KW_ERROR);
          end else begin
            lfsr_adv = 1'b1;
            bcnt_d   = bcnt_next;
            if (bcnt_next == '0) begin
              state_d     = S_RD_SEND_SUCCESS;
              out_valid_d = 1'b1;
              out_data_d  = kw(KW_SUCCESS);
            end
          end
        end
      end
      S_RD_SEND_ERROR: begin
        if (out_hs) begin
          state_d     = S_DONE;
          fail_d      = 1'b1;
          out_valid_d = 1'b0;
        end
      end
      S_RD_SEND_SUCCESS: begin
        if (out_hs) begin
          state_d     = S_DONE;
          pass_d      = 1'b1;
          out_valid_d = 1'b0;
        end
      end
      default: begin
        state_d     = S_IDLE;
        out_valid_d = 1'b0;
      end
    endcase

    // Watchdog: any handshake or state change counts as progress.
    if (!active || out_hs || in_hs || (state_d != state_q)) begin
      idle_d = '0;
    end else if (idle_q == TO_LIMIT) begin
      idle_d      = '0;
      state_d     = S_DONE;
      fail_d      = 1'b1;
      timeout_d   = 1'b1;
      pass_d      = 1'b0;
      out_valid_d = 1'b0;
    end else begin
      idle_d = idle_q + TO_W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      bcnt_q      <= '0;
      idle_q      <= '0;
      dir_q       <= 1'b0;
      seed_q      <= '0;
      wcnt_q      <= '0;
      pass_q      <= 1'b0;
      fail_q      <= 1'b0;
      timeout_q   <= 1'b0;
      err_rx_q    <= '0;
      err_exp_q   <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      bcnt_q      <= bcnt_d;
      idle_q      <= idle_d;
      dir_q       <= dir_d;
      seed_q      <= seed_d;
      wcnt_q      <= wcnt_d;
      pass_q      <= pass_d;
      fail_q      <= fail_d;
      timeout_q   <= timeout_d;
      err_rx_q    <= err_rx_d;
      err_exp_q   <= err_exp_d;
    end
  end

  assign busy         = active;
  assign done         = (state_q == S_DONE);
  assign pass         = pass_q;
  assign fail         = fail_q;
  assign timeout      = timeout_q;
  assign err_received = err_rx_q;
  assign err_expected = err_exp_q;

endmodule

// File: tb/tb_io_stress_test_initiator.sv
// Randomised scoreboard bench for io_stress_test_initiator: a responder model feeds the
// initiator and a monitor compares every outgoing word against a queue of expected words.

module tb_io_stress_test_initiator;

  localparam int WIDTH  = 16;
  localparam int LSHIFT = 2;
  localparam int TMO    = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              start, test_dir, rnd_wait, stall;
  logic [WIDTH-1:0]  seed;
  logic [15:0]       word_count;
  logic              fifo_out_valid, fifo_out_ready;
  logic [WIDTH-1:0]  fifo_out_data;
  logic              fifo_in_valid, fifo_in_ready;
  logic [WIDTH-1:0]  fifo_in_data;
  logic              busy, done, pass, fail, timeout;
  logic [WIDTH-1:0]  err_received, err_expected;

  io_stress_test_initiator #(
    .WIDTH             (WIDTH),
    .WORD_COUNT_LSHIFT (LSHIFT),
    .TIMEOUT_CYCLES    (TMO)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .test_dir       (test_dir),
    .rnd_wait       (rnd_wait),
    .seed           (seed),
    .word_count     (word_count),
    .stall          (stall),
    .fifo_out_valid (fifo_out_valid),
    .fifo_out_ready (fifo_out_ready),
    .fifo_out_data  (fifo_out_data),
    .fifo_in_valid  (fifo_in_valid),
    .fifo_in_ready  (fifo_in_ready),
    .fifo_in_data   (fifo_in_data),
    .busy           (busy),
    .done           (done),
    .pass           (pass),
    .fail           (fail),
    .timeout        (timeout),
    .err_received   (err_received),
    .err_expected   (err_expected)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  logic [15:0] exp_out[$];
  logic [15:0] rsp_q[$];
  int          out_seen, in_taken, target_out, first_hs_cyc, done_cyc, drv_cyc;
  bit          rd_mode, block_after_cmd;
  bit          exp_pass, exp_to;
  logic [15:0] exp_rx, exp_exp;
  int          exp_in;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return (v >> 1) ^ ((v % 2 == 1) ? 16'hB400 : 16'h0000);
  endfunction

  // Responder / flow-control driver: inputs change 1 time unit after the falling edge.
  initial begin
    bit force_cyc;
    bit in_ok;
    fifo_out_ready = 1'b0;
    fifo_in_valid  = 1'b0;
    fifo_in_data   = '0;
    stall          = 1'b0;
    drv_cyc        = 0;
    forever begin
      @(negedge clk); #1;
      force_cyc = (drv_cyc % 4 == 3);
      drv_cyc++;
      fifo_out_ready = !(block_after_cmd && out_seen >= 1) && (force_cyc || $urandom_range(0, 3) != 0);
      stall          = !force_cyc && ($urandom_range(0, 3) == 0);
      in_ok          = (rsp_q.size() > 0) && (rd_mode || out_seen >= target_out);
      fifo_in_valid  = in_ok && (force_cyc || $urandom_range(0, 2) != 0);
      fifo_in_data   = fifo_in_valid ? rsp_q[0] : '0;
    end
  end

  // Monitor: handshakes are sampled mid-cycle, before the edge that completes them.
  initial begin
    logic [15:0] want;
    forever begin
      @(negedge clk); #3;
      if (!rst && fifo_out_valid && fifo_out_ready) begin
        if (exp_out.size() == 0) begin
          n_checks++;
          $display("FAIL out_word: got %0h, expected no word (t=%0t)", fifo_out_data, $time);
        end else begin
          want = exp_out.pop_front();
          check("out_word", 64'(fifo_out_data), 64'(want));
        end
        if (out_seen == 0) first_hs_cyc = cyc;
        out_seen++;
      end
      if (!rst && fifo_in_valid && fifo_in_ready) begin
        if (rsp_q.size() > 0) void'(rsp_q.pop_front());
        in_taken++;
      end
    end
  end

  // bad: -1 clean, >=0 corrupted word index, -2 garbage verdict (write only)
  task automatic launch(input bit dir, input bit rw, input logic [15:0] sd,
                        input logic [15:0] cnt, input int bad);
    logic [15:0] words[$];
    logic [15:0] w;
    int          n;
    n = (int'(cnt) << LSHIFT) / (WIDTH / 8);
    exp_out.delete();
    rsp_q.delete();
    out_seen = 0;
    in_taken = 0;
    w = sd;
    for (int i = 0; i < n; i++) begin
      words.push_back(w);
      w = lfsr_step(w);
    end
    exp_out.push_back(16'h4200 | (rw ? 16'h0010 : 16'h0000) | (dir ? 16'h000B : 16'h000A));
    exp_out.push_back(sd);
    exp_out.push_back(cnt);
    exp_pass = 1'b1;
    exp_to   = 1'b0;
    exp_rx   = '0;
    exp_exp  = '0;
    if (!dir) begin
      rd_mode = 1'b0;
      foreach (words[i]) exp_out.push_back(words[i]);
      target_out = 3 + n;
      if (bad >= 0) begin
        rsp_q = '{16'hDEAD, 16'hBEEF, words[bad]};
        exp_pass = 1'b0; exp_rx = 16'hBEEF; exp_exp = words[bad]; exp_in = 3;
      end else if (bad == -2) begin
        rsp_q = '{16'h5A5A};
        exp_pass = 1'b0; exp_rx = 16'h5A5A; exp_in = 1;
      end else begin
        rsp_q = '{16'hCAFE};
        exp_in = 1;
      end
    end else begin
      rd_mode = 1'b1;
      target_out = 0;
      for (int i = 0; i < n; i++) rsp_q.push_back((i == bad) ? 16'h0000 : words[i]);
      if (bad >= 0) begin
        exp_out.push_back(16'hDEAD);
        exp_pass = 1'b0; exp_rx = 16'h0000; exp_exp = words[bad]; exp_in = bad + 1;
      end else begin
        exp_out.push_back(16'hCAFE);
        exp_in = n;
      end
    end
    @(negedge clk); #1;
    test_dir = dir; rnd_wait = rw; seed = sd; word_count = cnt; start = 1'b1;
    @(negedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 3000 && !seen; i++) begin
      @(negedge clk); #4;
      if (done) begin
        seen = 1'b1;
        done_cyc = cyc;
      end
    end
    check({name, "_done_reached"}, 64'(seen), 64'd1);
  endtask

  task automatic finish_test(input string name);
    wait_done(name);
    check({name, "_pass"},    64'(pass),         64'(exp_pass));
    check({name, "_fail"},    64'(fail),         64'(!exp_pass));
    check({name, "_timeout"}, 64'(timeout),      64'(exp_to));
    check({name, "_err_rx"},  64'(err_received), 64'(exp_rx));
    check({name, "_err_exp"}, 64'(err_expected), 64'(exp_exp));
    check({name, "_busy"},    64'(busy),         64'd0);
    check({name, "_out_left"}, 64'(exp_out.size()), 64'd0);
    check({name, "_in_taken"}, 64'(in_taken),    64'(exp_in));
  endtask

  task automatic check_quiet(input string name);
    check({name, "_busy"},      64'(busy),           64'd0);
    check({name, "_done"},      64'(done),           64'd0);
    check({name, "_pass"},      64'(pass),           64'd0);
    check({name, "_fail"},      64'(fail),           64'd0);
    check({name, "_timeout"},   64'(timeout),        64'd0);
    check({name, "_err_rx"},    64'(err_received),   64'd0);
    check({name, "_err_exp"},   64'(err_expected),   64'd0);
    check({name, "_out_valid"}, 64'(fifo_out_valid), 64'd0);
    check({name, "_in_ready"},  64'(fifo_in_ready),  64'd0);
  endtask

  initial begin
    bit          dir, rw;
    logic [15:0] cnt;
    int          bad, n;
    bit          reached;

    rst = 1'b1; start = 1'b0; test_dir = 1'b0; rnd_wait = 1'b0;
    seed = '0; word_count = '0; rd_mode = 1'b0; block_after_cmd = 1'b0;
    out_seen = 0; in_taken = 0; target_out = 0; first_hs_cyc = 0; done_cyc = 0;
    repeat (3) @(negedge clk);
    #4;
    check_quiet("reset");
    rst = 1'b0;

    launch(1'b0, 1'b0, 16'h1234, 16'd3, -1);
    finish_test("wr_ok");

    launch(1'b0, 1'b0, 16'h1234, 16'd3, 2);
    finish_test("wr_err");

    launch(1'b1, 1'b1, 16'hACE1, 16'd2, -1);
    finish_test("rd_ok");

    launch(1'b1, 1'b0, 16'hACE1, 16'd2, 3);
    finish_test("rd_err_last");

    launch(1'b0, 1'b0, 16'h0F0F, 16'd2, -2);
    finish_test("wr_garbage");

    // Watchdog: responder stops accepting after the command word.
    block_after_cmd = 1'b1;
    launch(1'b0, 1'b0, 16'h0005, 16'd3, -1);
    while (exp_out.size() > 1) void'(exp_out.pop_back());
    exp_pass = 1'b0; exp_to = 1'b1; exp_in = 0; rsp_q.delete();
    finish_test("timeout");
    check("timeout_latency", 64'(done_cyc - (first_hs_cyc + 1)), 64'(TMO));
    check("timeout_out_valid", 64'(fifo_out_valid), 64'd0);
    block_after_cmd = 1'b0;

    launch(1'b0, 1'b1, 16'h7E57, 16'd2, -1);
    finish_test("restart");

    launch(1'b0, 1'b0, 16'h2222, 16'd0, -1);
    finish_test("wr_zero");

    launch(1'b1, 1'b0, 16'h3333, 16'd0, -1);
    finish_test("rd_zero");

    for (int t = 0; t < 6; t++) begin
      dir = 1'($urandom_range(0, 1));
      rw  = 1'($urandom_range(0, 1));
      cnt = 16'($urandom_range(0, 4));
      n   = (int'(cnt) << LSHIFT) / (WIDTH / 8);
      bad = -1;
      if (n > 0 && $urandom_range(0, 1) == 1) bad = $urandom_range(0, n - 1);
      else if (!dir && $urandom_range(0, 3) == 0) bad = -2;
      launch(dir, rw, 16'($urandom_range(1, 65535)), cnt, bad);
      finish_test("random");
    end

    // Reset in the middle of a write stream.
    launch(1'b0, 1'b0, 16'h4D2C, 16'd4, -1);
    reached = 1'b0;
    for (int i = 0; i < 500 && !reached; i++) begin
      @(negedge clk); #4;
      if (out_seen >= 6) reached = 1'b1;
    end
    check("midstream_reached", 64'(reached), 64'd1);
    @(negedge clk); #1;
    rst = 1'b1;
    @(negedge clk); #4;
    check_quiet("midstream_reset");
    rst = 1'b0;
    exp_out.delete();
    rsp_q.delete();

    launch(1'b1, 1'b0, 16'h1111, 16'd3, -1);
    finish_test("after_reset");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/io_stress_test_initiator.md
Name: io_stress_test_initiator

Overview:
Host-side counterpart of the GLIP I/O stress test responder, for loopback benches and FPGA-to-FPGA links. Issues the start command, seed and word count, then runs one test:
- Write test: streams LFSR data toward the responder and collects its SUCCESS/ERROR verdict.
- Read test: checks the responder's LFSR stream and returns SUCCESS or ERROR.

Sits directly on a GLIP FIFO pair, with the responder on the far side.

Parameters:
WIDTH, 16, data word width in bits; must be >= 16; keywords occupy bits [15:0], upper bits zero.
WORD_COUNT_LSHIFT, 20, left shift applied to the 16-bit count word to form the byte count; range 0..20.
TIMEOUT_CYCLES, 65535, consecutive cycles without any completed handshake in a non-IDLE/non-DONE state before abort.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
start  in  1  one-cycle pulse; accepted only in IDLE or DONE
test_dir  in  1  0 = write test (initiator -> responder), 1 = read test (responder -> initiator); sampled on start
rnd_wait  in  1  1 = request random-wait variant; sampled on start
seed  in  WIDTH  LFSR seed; sampled on start
word_count  in  16  count word; sampled on start
stall  in  1  0-cycle-latency throttle; suppresses out-valid in WR_STREAM and in-ready in RD_STREAM
fifo_out_valid  out  1  toward responder
fifo_out_ready  in  1
fifo_out_data  out  WIDTH
fifo_in_valid  in  1  from responder
fifo_in_ready  out  1
fifo_in_data  in  WIDTH
busy  out  1  high in every state except IDLE/DONE
done  out  1  level; high in DONE
pass  out  1  valid when done
fail  out  1  valid when done; pass and fail never both 1
timeout  out  1  valid when done; fail cause was timeout
err_received  out  WIDTH  failing word (see below)
err_expected  out  WIDTH  expected word

Behaviour:
- Reset, any cycle including mid-test: state IDLE; all outputs 0; byte counter 0; LFSR not reseeded.
- Keywords:
  - start-write 0x420A, or 0x421A when rnd_wait = 1
  - start-read 0x420B, or 0x421B when rnd_wait = 1
  - SUCCESS 0xCAFE
  - ERROR 0xDEAD
- Byte counter: 36 bits, equal to word_count << WORD_COUNT_LSHIFT; decremented by WIDTH/8 per data word transferred. A count of 0 skips streaming.
- LFSR: one stress_test_lfsr instance of width WIDTH.
  - Seed loads on the seed-word handshake; the first data word is the LFSR output after seeding.
  - Advances once per transferred data word.
- Outputs registered: fifo_out_valid and fifo_out_data are held stable until the ready handshake.
- All transfers complete on valid & ready in the same cycle; the next word may be offered the following cycle, giving one word per cycle at full rate.
- FSM:
  - IDLE/DONE: start -> SEND_CMD; clears pass/fail/timeout/err_* and latches the inputs.
  - SEND_CMD -> SEND_SEED -> SEND_COUNT: each presents its word and advances on handshake.
  - SEND_COUNT: on handshake -> WR_STREAM if test_dir = 0, else RD_STREAM.
  - WR_STREAM: while counter > 0 and !stall, offer the LFSR word. Counter reaching 0 -> WR_RESULT. fifo_in_ready = 0 except that an ERROR word arriving mid-stream goes to WR_ERR_RX.
  - WR_RESULT: fifo_in_ready = 1.
    - SUCCESS -> DONE with pass.
    - ERROR -> WR_ERR_RX.
    - Any other word -> DONE with fail; err_received = that word.
  - WR_ERR_RX: next word -> err_received, then WR_ERR_EXP.
  - WR_ERR_EXP: next word -> err_expected, then DONE with fail.
  - RD_STREAM: fifo_in_ready = !stall.
    - Word equal to LFSR: advance and decrement.
    - Mismatch: latch err_received/err_expected, -> RD_SEND_ERROR.
    - Counter 0 -> RD_SEND_SUCCESS.
  - RD_SEND_ERROR: send ERROR; on handshake -> DONE with fail.
  - RD_SEND_SUCCESS: send SUCCESS; on handshake -> DONE with pass.
- Timeout: a counter resets on any handshake or state change. On reaching TIMEOUT_CYCLES -> DONE with fail = timeout = 1 and fifo_out_valid dropped.
- start while busy is ignored.
- A mismatch and a counter-zero condition in the same cycle: mismatch wins.

Test Plan:
1. WORD_COUNT_LSHIFT = 2, write test, seed 0x1234, count 3, ideal responder. Out sequence is 0x420A, 0x1234, 0x0003, then 6 LFSR words. Responder replies 0xCAFE. Result: done = 1, pass = 1.
2. Same setup, but the responder corrupts word 2 and replies 0xDEAD, 0xBEEF, then the expected value. Result: fail = 1, err_received = 0xBEEF, err_expected = LFSR word 2.
3. Read test, rnd_wait = 1, seed 0xACE1, count 2. Cmd 0x421B is sent; 4 correct words are supplied with fifo_in_valid gaps and stall toggling. Result: out 0xCAFE, pass = 1, no word dropped or duplicated.
4. Read test with word 3 flipped to 0x0000. Result: out 0xDEAD, fail = 1, err_received = 0x0000.
5. TIMEOUT_CYCLES = 16, fifo_out_ready held 0 after cmd. Result: done after 16 idle cycles, fail = timeout = 1. A new start restarts cleanly.
6. Count 0, write test. Result: no data words; immediately WR_RESULT; 0xCAFE -> pass. Reset asserted mid-stream: next cycle IDLE, all outputs 0.
